seg7_display_ctrl: RTL and testbench

Sequencing and arbitration controller for the 4-digit seven-segment display device. It shares the display between two requesters (game logic and status/message logic) using round-robin arbitration, and holds the granted payload (hex digits, decimal points, blink enables). Each new payload triggers a load/shift/latch sequence for the 64-bit serial output register. It also generates the free-running 2-bit digit-scan select and the blink phase that the display device consumes.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_display_ctrl_scan_gen.sv | 72 +++++++
 rtl/seg7_display_ctrl.sv | 127 ++++++++++++
 tb/tb_seg7_display_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment display controller.
//   - FSM state encoding for the load/shift/latch update sequence
//   - digit count and payload field widths
//   - packed payload record captured from the granted requester
package seg7_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NUM_REQ    = 2;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned POINT_W    = 4;
   localparam int unsigned LES_W      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [POINT_W-1:0] point;
      logic [LES_W-1:0]   les;
   } payload_t;

endpackage

// File: rtl/seg7_display_ctrl_scan_gen.sv
// seg7_scan_gen: free-running digit-scan select and blink phase generator.
// Build option: SEG7_BLINK_EN compiles in the frame counter and blink toggle;
// without it blink is tied to 1 (segments always visible).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   scan      - 2-bit digit select, advances every SCAN_DIV cycles
//   blink     - blink phase, toggles every BLINK_DIV complete scan frames
module seg7_scan_gen
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLINK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] scan,
   output logic       blink
);

   localparam int unsigned SCAN_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   // Elaboration guard on divider ranges.
   if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
      $error("seg7_scan_gen: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
   end

   logic [SCAN_CW-1:0] div_cnt;
   logic               scan_step;

   assign scan_step = (div_cnt == SCAN_CW'(SCAN_DIV - 1));

   // Scan divider and digit select.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         scan    <= 2'd0;
      end else if (scan_step) begin
         div_cnt <= '0;
         scan    <= scan + 2'd1;
      end else begin
         div_cnt <= div_cnt + SCAN_CW'(1);
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int unsigned FRAME_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [FRAME_CW-1:0] frame_cnt;
   logic                frame_end;

   // A frame ends when the scan wraps from the last digit back to digit 0.
   assign frame_end = scan_step && (scan == 2'(NUM_DIGITS - 1));

   // Frame counter and blink toggle.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         blink     <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt == FRAME_CW'(BLINK_DIV - 1)) begin
            frame_cnt <= '0;
            blink     <= ~blink;
         end else begin
            frame_cnt <= frame_cnt + FRAME_CW'(1);
         end
      end
   end
`else
   assign blink = 1'b1;
`endif

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: shares the 4-digit seven-segment display between two
// requesters with round-robin arbitration, holds the granted payload and runs
// the load/shift/latch sequence for the 64-bit serial output register.
// Build option: SEG7_BLINK_EN (see seg7_scan_gen) enables the blink phase.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req                 - per-requester level request, held until ack
//   req_data/point/les  - per-requester payloads (16/4/4 bits each)
//   ack                 - one-cycle one-hot grant pulse (in the LOAD cycle)
//   disp_data/point/les - held payload of the last grant
//   scan, blink         - digit-scan select and blink phase
//   io_load/shift/latch - serial register control strobes
//   busy                - high whenever an update sequence is in progress
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned SHIFT_WIDTH = 64,
   parameter int unsigned SCAN_DIV    = 50000,
   parameter int unsigned BLINK_DIV   = 100
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ*POINT_W-1:0]  req_point,
   input  logic [NUM_REQ*LES_W-1:0]    req_les,
   output logic [NUM_REQ-1:0]          ack,
   output logic [DATA_W-1:0]           disp_data,
   output logic [POINT_W-1:0]          disp_point,
   output logic [LES_W-1:0]            disp_les,
   output logic [1:0]                  scan,
   output logic                        blink,
   output logic                        io_load,
   output logic                        io_shift,
   output logic                        io_latch,
   output logic                        busy
);

   localparam int unsigned CNT_W = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   shift_cnt, shift_cnt_nxt;
   logic               last_grant;
   logic               grant_vld;
   logic               grant_idx;
   payload_t           grant_payload;
   logic [NUM_REQ-1:0] ack_nxt;

   // Round-robin pick: a lone requester always wins; on contention the
   // requester that was not granted last time wins.
   always_comb begin
      grant_idx = (req[0] && req[1]) ? ~last_grant : req[1];
      grant_payload.data  = req_data[DATA_W*grant_idx +: DATA_W];
      grant_payload.point = req_point[POINT_W*grant_idx +: POINT_W];
      grant_payload.les   = req_les[LES_W*grant_idx +: LES_W];
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      shift_cnt_nxt = '0;
      grant_vld     = 1'b0;
      ack_nxt       = '0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = LOAD;
               grant_vld = 1'b1;
               ack_nxt   = NUM_REQ'(2'b01 << grant_idx);
            end
         end
         LOAD: state_nxt = SHIFT;
         SHIFT: begin
            if (shift_cnt == CNT_W'(SHIFT_WIDTH - 1)) begin
               state_nxt = LATCH;
            end else begin
               shift_cnt_nxt = shift_cnt + CNT_W'(1);
            end
         end
         LATCH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; strobes are registered from the next state so they line
   // up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shift_cnt  <= '0;
         last_grant <= 1'b1;
         ack        <= '0;
         io_load    <= 1'b0;
         io_shift   <= 1'b0;
         io_latch   <= 1'b0;
         busy       <= 1'b0;
         disp_data  <= '0;
         disp_point <= '0;
         disp_les   <= '0;
      end else begin
         state      <= state_nxt;
         shift_cnt  <= shift_cnt_nxt;
         ack        <= ack_nxt;
         io_load    <= (state_nxt == LOAD);
         io_shift   <= (state_nxt == SHIFT);
         io_latch   <= (state_nxt == LATCH);
         busy       <= (state_nxt != IDLE);
         if (grant_vld) begin
            last_grant <= grant_idx;
            disp_data  <= grant_payload.data;
            disp_point <= grant_payload.point;
            disp_les   <= grant_payload.les;
         end
      end
   end

   seg7_scan_gen #(
      .SCAN_DIV  (SCAN_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) u_scan_gen (
      .clk   (clk),
      .rst   (rst),
      .scan  (scan),
      .blink (blink)
   );

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: table-driven grant vectors,
// hand-written multi-cycle sequences and randomized traffic, all compared
// cycle by cycle against a behavioural model.
module tb_seg7_display_ctrl;

   localparam int unsigned SW = 64;
   localparam int unsigned SD = 4;
   localparam int unsigned BD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [31:0] req_data;
   logic [7:0]  req_point;
   logic [7:0]  req_les;
   logic [1:0]  ack;
   logic [15:0] disp_data;
   logic [3:0]  disp_point;
   logic [3:0]  disp_les;
   logic [1:0]  scan;
   logic        blink;
   logic        io_load;
   logic        io_shift;
   logic        io_latch;
   logic        busy;

   always #5 clk = ~clk;

   seg7_display_ctrl #(
      .SHIFT_WIDTH (SW),
      .SCAN_DIV    (SD),
      .BLINK_DIV   (BD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .req_point  (req_point),
      .req_les    (req_les),
      .ack        (ack),
      .disp_data  (disp_data),
      .disp_point (disp_point),
      .disp_les   (disp_les),
      .scan       (scan),
      .blink      (blink),
      .io_load    (io_load),
      .io_shift   (io_shift),
      .io_latch   (io_latch),
      .busy       (busy)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Behavioural model: m_phase is the number of cycles since the grant
   // (0 = idle), m_c the number of non-reset clock edges since reset.
   int unsigned m_phase;
   int unsigned m_c;
   int          m_win;
   logic        m_last;
   logic [15:0] m_data;
   logic [3:0]  m_point;
   logic [3:0]  m_les;

   task automatic model_step();
      if (rst) begin
         m_phase = 0;
         m_c     = 0;
         m_win   = 0;
         m_last  = 1'b1;
         m_data  = '0;
         m_point = '0;
         m_les   = '0;
      end else begin
         m_c++;
         if (m_phase == 0) begin
            if (req != 2'b00) begin
               if (req == 2'b11)      m_win = m_last ? 0 : 1;
               else if (req == 2'b01) m_win = 0;
               else                   m_win = 1;
               m_last  = (m_win == 1);
               m_data  = req_data[16*m_win +: 16];
               m_point = req_point[4*m_win +: 4];
               m_les   = req_les[4*m_win +: 4];
               m_phase = 1;
            end
         end else if (m_phase == SW + 2) begin
            m_phase = 0;
         end else begin
            m_phase++;
         end
      end
   endtask

   function automatic logic [32:0] model_vec();
      logic [1:0] a;
      logic [1:0] sc;
      logic       bl;
      a  = (m_phase == 1) ? ((m_win == 1) ? 2'b10 : 2'b01) : 2'b00;
      sc = 2'((m_c / SD) % 4);
`ifdef SEG7_BLINK_EN
      bl = (((m_c / (4 * SD * BD)) % 2) == 0);
`else
      bl = 1'b1;
`endif
      return {a, m_data, m_point, m_les, sc, bl,
              1'(m_phase == 1), 1'(m_phase >= 2 && m_phase <= SW + 1),
              1'(m_phase == SW + 2), 1'(m_phase != 0)};
   endfunction

   function automatic logic [32:0] dut_vec();
      return {ack, disp_data, disp_point, disp_les, scan, blink,
              io_load, io_shift, io_latch, busy};
   endfunction

   task automatic check_val(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: advance the model on the edge, compare all outputs just after.
   task automatic tick();
      logic [32:0] g, e;
      @(posedge clk);
      model_step();
      #1;
      g = dut_vec();
      e = model_vec();
      n_vec++;
      if (g !== e) begin
         n_err++;
         $display("FAIL cycle: got %h expected %h (phase %0d) at %0t",
                  g, e, m_phase, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 2'b00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Runs from offset 1 (LOAD cycle) until busy drops.
   task automatic run_to_idle(output int shifts, output int latch_at,
                              output int idle_at);
      shifts   = 0;
      latch_at = -1;
      idle_at  = -1;
      for (int k = 2; k < 200; k++) begin
         tick();
         if (io_shift) shifts++;
         if (io_latch) latch_at = k;
         if (!busy) begin
            idle_at = k;
            break;
         end
      end
   endtask

   // Waits for the next ack, returning its offset (-1 on timeout).
   task automatic wait_ack(input int start, output int at);
      at = -1;
      for (int k = start; k < start + 200; k++) begin
         tick();
         if (ack != 2'b00) begin
            at = k;
            break;
         end
      end
      if (at < 0) check_val("ack_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [31:0] data;
      logic [7:0]  point;
      logic [7:0]  les;
      logic [1:0]  exp_ack;
      logic [15:0] exp_data;
      logic [3:0]  exp_point;
      logic [3:0]  exp_les;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int shifts, latch_at, idle_at, at, latches, scan_chg, blink_chg;
      logic [1:0] prev_scan, pend;
      logic       prev_blink;

      rst       = 1'b1;
      req       = 2'b00;
      req_data  = '0;
      req_point = '0;
      req_les   = '0;

      // Applied in order without reset, so the round-robin pointer carries over.
      tbl[0] = '{2'b01, 32'hABCD_1234, 8'h52, 8'hA0, 2'b01, 16'h1234, 4'h2, 4'h0};
      tbl[1] = '{2'b11, 32'h5678_9ABC, 8'h3C, 8'h96, 2'b10, 16'h5678, 4'h3, 4'h9};
      tbl[2] = '{2'b11, 32'h0F0F_F0F0, 8'h81, 8'h7E, 2'b01, 16'hF0F0, 4'h1, 4'hE};
      tbl[3] = '{2'b10, 32'hDEAD_BEEF, 8'hC5, 8'h4B, 2'b10, 16'hDEAD, 4'hC, 4'h4};
      tbl[4] = '{2'b10, 32'h1111_2222, 8'hF0, 8'h0F, 2'b10, 16'h1111, 4'hF, 4'h0};
      tbl[5] = '{2'b01, 32'h3333_4444, 8'h12, 8'h34, 2'b01, 16'h4444, 4'h2, 4'h4};
      tbl[6] = '{2'b11, 32'hFFFF_0000, 8'h6A, 8'h5C, 2'b10, 16'hFFFF, 4'h6, 4'h5};

      // Reset state.
      do_reset();
      check_val("rst_outputs", 32'(dut_vec()), 32'h0000_0000 | 32'h10);
      check_val("rst_scan", 32'(scan), 32'd0);
      check_val("rst_blink", 32'(blink), 32'd1);

      // Table: grant selection, payload capture and sequence timing.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         req       = tbl[i].req;
         req_data  = tbl[i].data;
         req_point = tbl[i].point;
         req_les   = tbl[i].les;
         tick();
         check_val("tbl_ack", 32'(ack), 32'(tbl[i].exp_ack));
         check_val("tbl_load", 32'(io_load), 32'd1);
         check_val("tbl_data", 32'(disp_data), 32'(tbl[i].exp_data));
         check_val("tbl_point", 32'(disp_point), 32'(tbl[i].exp_point));
         check_val("tbl_les", 32'(disp_les), 32'(tbl[i].exp_les));
         req       = 2'b00;
         req_data  = 32'($urandom);
         run_to_idle(shifts, latch_at, idle_at);
         check_val("tbl_shift_cnt", 32'(shifts), 32'(SW));
         check_val("tbl_latch_at", 32'(latch_at), 32'(SW + 2));
         check_val("tbl_idle_at", 32'(idle_at), 32'(SW + 3));
         check_val("tbl_data_hold", 32'(disp_data), 32'(tbl[i].exp_data));
      end

      // Contention with both held, each dropping after its ack.
      do_reset();
      req       = 2'b11;
      req_data  = 32'hBBBB_AAAA;
      req_point = 8'h21;
      req_les   = 8'h43;
      tick();
      check_val("rr_first", 32'(ack), 32'h1);
      req = 2'b10;
      wait_ack(2, at);
      check_val("rr_second", 32'(ack), 32'h2);
      check_val("rr_second_at", 32'(at), 32'(SW + 4));
      check_val("rr_second_data", 32'(disp_data), 32'hBBBB);
      req = 2'b11;
      wait_ack(1, at);
      check_val("rr_third", 32'(ack), 32'h1);
      req = 2'b00;
      run_to_idle(shifts, latch_at, idle_at);

      // Request raised during SHIFT waits for IDLE.
      req = 2'b01;
      tick();
      check_val("mid_first", 32'(ack), 32'h1);
      req = 2'b00;
      for (int k = 2; k <= 10; k++) tick();
      req = 2'b10;
      wait_ack(11, at);
      check_val("mid_ack", 32'(ack), 32'h2);
      check_val("mid_ack_at", 32'(at), 32'(SW + 4));
      req = 2'b00;
      run_to_idle(shifts, latch_at, idle_at);

      // Reset at shift count 30 aborts the sequence without a latch.
      req       = 2'b01;
      req_data  = 32'h0000_9876;
      tick();
      req = 2'b00;
      for (int k = 2; k <= 32; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rstmid_state", 32'({io_load, io_shift, io_latch, busy}), 32'h0);
      check_val("rstmid_data", 32'(disp_data), 32'h0);
      latches = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (io_latch) latches++;
      end
      check_val("rstmid_no_latch", 32'(latches), 32'd0);

      // Free-running scan and blink.
      do_reset();
      prev_scan  = scan;
      prev_blink = blink;
      scan_chg   = 0;
      blink_chg  = 0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (scan != prev_scan) scan_chg++;
         if (blink != prev_blink) blink_chg++;
         prev_scan  = scan;
         prev_blink = blink;
      end
      check_val("scan_steps", 32'(scan_chg), 32'd20);
`ifdef SEG7_BLINK_EN
      check_val("blink_toggles", 32'(blink_chg), 32'd2);
`else
      check_val("blink_toggles", 32'(blink_chg), 32'd0);
`endif

      // Randomized traffic obeying the request/ack handshake.
      pend = 2'b00;
      for (int i = 0; i < 3000; i++) begin
         for (int r = 0; r < 2; r++)
            if (!pend[r] && $urandom_range(0, 3) == 0) pend[r] = 1'b1;
         req       = pend;
         req_data  = 32'($urandom);
         req_point = 8'($urandom);
         req_les   = 8'($urandom);
         rst       = ($urandom_range(0, 499) == 0);
         tick();
         pend = rst ? 2'b00 : (pend & ~ack);
      end
      rst = 1'b0;
      req = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
